ext_mem_responder: RTL and testbench

- Synthesizable, dual-channel, byte-lane external memory slave that connects directly to the accelerator's Mout_* master memory port. It returns M_Rdata_ram and M_DataRdy to the accelerator.
- It replaces the behavioural off-chip memory in FPGA-in-the-loop runs. The memory is preloaded through a side port and read back through the same port after done.
- Programmable read and write latency lets cycle counts be characterised against memory delay.

---
 rtl/ext_mem_pkg.sv | 36 +++
 rtl/ext_mem_chan_fsm.sv | 114 +++++++++++
 rtl/ext_mem_responder.sv | 122 ++++++++++++
 tb/tb_ext_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared types and helpers for the external memory responder
// Contents:
//   chan_state_e  per-channel FSM state (IDLE, RD_WAIT, WR_WAIT, DONE)
//   LANE_W        byte lane width
//   SIZE_W        access-size field width
//   size_to_mask  access size in bits -> byte lane mask
//   in_range      address window test
package ext_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_DONE
  } chan_state_e;

  localparam int LANE_W = 8;
  localparam int SIZE_W = 4;

  // Sizes 1..7 select the low bits; 0 and anything >= 8 mean the full byte.
  function automatic logic [LANE_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size);
    logic [LANE_W-1:0] m;
    m = '1;
    if (size != '0 && size < SIZE_W'(LANE_W)) begin
      m = ~(8'hFF << size);
    end
    return m;
  endfunction

  function automatic logic in_range(input int unsigned addr,
                                    input int unsigned base,
                                    input int unsigned size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/ext_mem_chan_fsm.sv
// rtl/ext_mem_chan_fsm.sv - one byte channel of the external memory responder
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   oe, we              read / write request from the accelerator
//   addr, wdata, size   request address, write byte, access size in bits
//   rd_byte             backing-store byte at rd_off (combinational from top)
//   rd_off              latched store offset of the current access
//   wr_en               write commits to the store on this edge
//   wr_off, wr_data     write offset / byte
//   wr_mask             lane mask for the write
//   rdata, rdy          registered read byte and completion pulse
//   idle                channel is in IDLE
//   conflict            oe and we asserted together
module ext_mem_chan_fsm
  import ext_mem_pkg::*;
#(
  parameter int          ADDR_W      = 7,
  parameter int          OFF_W       = 5,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MEM_SIZE    = 32,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              oe,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANE_W-1:0] wdata,
  input  logic [SIZE_W-1:0] size,
  input  logic [LANE_W-1:0] rd_byte,
  output logic [OFF_W-1:0]  rd_off,
  output logic              wr_en,
  output logic [OFF_W-1:0]  wr_off,
  output logic [LANE_W-1:0] wr_data,
  output logic [LANE_W-1:0] wr_mask,
  output logic [LANE_W-1:0] rdata,
  output logic              rdy,
  output logic              idle,
  output logic              conflict
);

  chan_state_e       state;
  logic [7:0]        cnt;
  logic [LANE_W-1:0] mask_q;
  logic              hit;
  logic [OFF_W-1:0]  req_off;

  assign hit      = in_range(32'(addr), BASE_ADDR, MEM_SIZE);
  assign req_off  = OFF_W'(32'(addr) - BASE_ADDR);
  assign idle     = (state == ST_IDLE);
  assign conflict = oe & we;

  // Writes land in the store on the accept edge; the wait state only
  // delays the completion pulse.
  assign wr_en   = idle & we & ~oe & hit;
  assign wr_off  = req_off;
  assign wr_data = wdata;
  assign wr_mask = size_to_mask(size);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rd_off <= '0;
      mask_q <= '0;
      rdata  <= '0;
      rdy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rdy   <= 1'b0;
          rdata <= '0;
          if (oe && !we && hit) begin
            state  <= ST_RD_WAIT;
            cnt    <= 8'd1;
            rd_off <= req_off;
            mask_q <= size_to_mask(size);
          end else if (we && !oe && hit) begin
            state  <= ST_WR_WAIT;
            cnt    <= 8'd1;
            rd_off <= req_off;
            mask_q <= size_to_mask(size);
          end
        end
        ST_RD_WAIT: begin
          // Store is sampled here, before any same-edge write lands.
          if (cnt >= 8'(READ_DELAY)) begin
            state <= ST_DONE;
            rdy   <= 1'b1;
            rdata <= rd_byte & mask_q;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_WR_WAIT: begin
          if (cnt >= 8'(WRITE_DELAY)) begin
            state <= ST_DONE;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          rdy   <= 1'b0;
          rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - dual-channel byte-lane external memory slave with side port
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   Mout_oe_ram           per-channel read request
//   Mout_we_ram           per-channel write request
//   Mout_addr_ram         per-channel byte address, channel c at [c*ADDR_W +: ADDR_W]
//   Mout_Wdata_ram        per-channel write byte
//   Mout_data_ram_size    per-channel access size in bits
//   M_Rdata_ram           per-channel read byte, zero outside the ready cycle
//   M_DataRdy             per-channel completion pulse
//   ld_en, ld_we          side-port strobe and direction
//   ld_addr, ld_wdata     side-port offset and write byte
//   ld_rdata              registered side-port read byte
//   err                   sticky protocol error
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int          N_CH        = 2,
  parameter int          ADDR_W      = 7,
  parameter int unsigned MEM_SIZE    = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_CH-1:0]               Mout_oe_ram,
  input  logic [N_CH-1:0]               Mout_we_ram,
  input  logic [N_CH*ADDR_W-1:0]        Mout_addr_ram,
  input  logic [N_CH*LANE_W-1:0]        Mout_Wdata_ram,
  input  logic [N_CH*SIZE_W-1:0]        Mout_data_ram_size,
  output logic [N_CH*LANE_W-1:0]        M_Rdata_ram,
  output logic [N_CH-1:0]               M_DataRdy,
  input  logic                          ld_en,
  input  logic                          ld_we,
  input  logic [$clog2(MEM_SIZE)-1:0]   ld_addr,
  input  logic [LANE_W-1:0]             ld_wdata,
  output logic [LANE_W-1:0]             ld_rdata,
  output logic                          err
);

  localparam int OFF_W = $clog2(MEM_SIZE);

  logic [LANE_W-1:0] mem [MEM_SIZE];

  logic [OFF_W-1:0]  rd_off   [N_CH];
  logic [LANE_W-1:0] rd_byte  [N_CH];
  logic [OFF_W-1:0]  wr_off   [N_CH];
  logic [LANE_W-1:0] wr_data  [N_CH];
  logic [LANE_W-1:0] wr_mask  [N_CH];
  logic [N_CH-1:0]   wr_en;
  logic [N_CH-1:0]   idle;
  logic [N_CH-1:0]   conflict;
  logic              all_idle;
  logic              ld_ok;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ext_mem_chan_fsm #(
      .ADDR_W      (ADDR_W),
      .OFF_W       (OFF_W),
      .BASE_ADDR   (BASE_ADDR),
      .MEM_SIZE    (MEM_SIZE),
      .READ_DELAY  (READ_DELAY),
      .WRITE_DELAY (WRITE_DELAY)
    ) u_fsm (
      .clock    (clock),
      .reset    (reset),
      .oe       (Mout_oe_ram[c]),
      .we       (Mout_we_ram[c]),
      .addr     (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
      .wdata    (Mout_Wdata_ram[c*LANE_W +: LANE_W]),
      .size     (Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
      .rd_byte  (rd_byte[c]),
      .rd_off   (rd_off[c]),
      .wr_en    (wr_en[c]),
      .wr_off   (wr_off[c]),
      .wr_data  (wr_data[c]),
      .wr_mask  (wr_mask[c]),
      .rdata    (M_Rdata_ram[c*LANE_W +: LANE_W]),
      .rdy      (M_DataRdy[c]),
      .idle     (idle[c]),
      .conflict (conflict[c])
    );

    assign rd_byte[c] = mem[rd_off[c]];
  end

  assign all_idle = &idle;
  assign ld_ok    = ld_en & all_idle & (32'(ld_addr) < MEM_SIZE);

  // Backing store keeps its contents across reset. Channels are applied
  // in ascending order so the highest index wins a same-address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (ld_ok && ld_we) begin
        mem[ld_addr] <= ld_wdata;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (wr_en[c]) begin
          mem[wr_off[c]] <= (wr_data[c] & wr_mask[c]) | (mem[wr_off[c]] & ~wr_mask[c]);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_rdata <= '0;
    end else if (ld_ok && !ld_we) begin
      ld_rdata <= mem[ld_addr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if ((|conflict) || (ld_en && !all_idle)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb/tb_ext_mem_responder.sv - self-checking bench for ext_mem_responder
module tb_ext_mem_responder;

  localparam int N_CH        = 2;
  localparam int ADDR_W      = 7;
  localparam int MEM_SIZE    = 32;
  localparam int READ_DELAY  = 2;
  localparam int WRITE_DELAY = 1;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [N_CH-1:0]        oe    = '0;
  logic [N_CH-1:0]        we    = '0;
  logic [N_CH*ADDR_W-1:0] addr  = '0;
  logic [N_CH*8-1:0]      wdata = '0;
  logic [N_CH*4-1:0]      size  = '0;
  logic [N_CH*8-1:0]      M_Rdata_ram;
  logic [N_CH-1:0]        M_DataRdy;
  logic                   ld_en    = 1'b0;
  logic                   ld_we    = 1'b0;
  logic [4:0]             ld_addr  = '0;
  logic [7:0]             ld_wdata = '0;
  logic [7:0]             ld_rdata;
  logic                   err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] model [MEM_SIZE];

  ext_mem_responder #(
    .N_CH        (N_CH),
    .ADDR_W      (ADDR_W),
    .MEM_SIZE    (MEM_SIZE),
    .BASE_ADDR   (0),
    .READ_DELAY  (READ_DELAY),
    .WRITE_DELAY (WRITE_DELAY)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (oe),
    .Mout_we_ram        (we),
    .Mout_addr_ram      (addr),
    .Mout_Wdata_ram     (wdata),
    .Mout_data_ram_size (size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .ld_en              (ld_en),
    .ld_we              (ld_we),
    .ld_addr            (ld_addr),
    .ld_wdata           (ld_wdata),
    .ld_rdata           (ld_rdata),
    .err                (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] mask_of(input int sz);
    if (sz == 0 || sz >= 8) return 8'hFF;
    return 8'((1 << sz) - 1);
  endfunction

  task automatic side_wr(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = 5'(a); ld_wdata = d;
    tick();
    ld_en = 1'b0; ld_we = 1'b0;
    model[a] = d;
  endtask

  task automatic side_rd(input int a, input string tag);
    ld_en = 1'b1; ld_we = 1'b0; ld_addr = 5'(a);
    tick();
    ld_en = 1'b0;
    chk(tag, 32'(ld_rdata), 32'(model[a]));
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr, input int a,
                         input logic [7:0] d, input int sz);
    oe[c] = rd;
    we[c] = wr;
    addr[c*ADDR_W +: ADDR_W] = 7'(a);
    wdata[c*8 +: 8] = d;
    size[c*4 +: 4] = 4'(sz);
  endtask

  task automatic clear_req();
    oe = '0;
    we = '0;
  endtask

  // One isolated transaction: accept, then walk the pulse window cycle by cycle.
  task automatic run_txn(input int c, input bit wr, input int a, input logic [7:0] d,
                         input int sz, input string tag);
    int         dly;
    bit         inr;
    logic [7:0] exp_b;
    logic [7:0] m;
    dly   = wr ? WRITE_DELAY : READ_DELAY;
    inr   = (a < MEM_SIZE);
    m     = mask_of(sz);
    exp_b = 8'h00;
    if (inr && !wr) exp_b = model[a] & m;
    set_req(c, !wr, wr, a, d, sz);
    tick();
    clear_req();
    if (inr && wr) model[a] = (d & m) | (model[a] & ~m);
    for (int i = 1; i <= dly + 1; i++) begin
      tick();
      if (inr && i == dly) begin
        chk($sformatf("%s_rdy_c%0d", tag, i), 32'(M_DataRdy), 32'(1 << c));
        chk($sformatf("%s_data_c%0d", tag, i), 32'(M_Rdata_ram), 32'(16'(exp_b) << (8 * c)));
      end else begin
        chk($sformatf("%s_rdy_c%0d", tag, i), 32'(M_DataRdy), 32'd0);
        chk($sformatf("%s_data_c%0d", tag, i), 32'(M_Rdata_ram), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] old_b;
    int         c, a, sz;
    bit         wr;

    // Reset state
    repeat (3) tick();
    chk("rst_rdy",    32'(M_DataRdy),   32'd0);
    chk("rst_rdata",  32'(M_Rdata_ram), 32'd0);
    chk("rst_ldrd",   32'(ld_rdata),    32'd0);
    chk("rst_err",    32'(err),         32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < MEM_SIZE; i++) side_wr(i, 8'($urandom));

    // Preloaded byte read back over channel 0
    side_wr(3, 8'hA5);
    run_txn(0, 1'b0, 3, 8'h00, 8, "rd_a5");

    // Masked nibble write over an existing byte
    side_wr(5, 8'h30);
    run_txn(1, 1'b1, 5, 8'hFF, 4, "wr_nib");
    side_rd(5, "wr_nib_rb");
    chk("wr_nib_3f", 32'(ld_rdata), 32'h3F);

    // Same-address simultaneous writes: higher channel wins
    set_req(0, 1'b0, 1'b1, 7, 8'h11, 8);
    set_req(1, 1'b0, 1'b1, 7, 8'h22, 8);
    tick();
    clear_req();
    model[7] = 8'h22;
    tick();
    chk("dual_wr_rdy", 32'(M_DataRdy), 32'd3);
    tick();
    chk("dual_wr_rdy_off", 32'(M_DataRdy), 32'd0);
    side_rd(7, "dual_wr_rb");

    // Read captures on the same edge as another channel's write: old byte
    old_b = model[9];
    set_req(0, 1'b1, 1'b0, 9, 8'h00, 8);
    tick();
    clear_req();
    tick();
    set_req(1, 1'b0, 1'b1, 9, ~old_b, 8);
    tick();
    clear_req();
    model[9] = ~old_b;
    chk("rbw_rdy0",  32'(M_DataRdy),   32'd1);
    chk("rbw_data0", 32'(M_Rdata_ram), 32'(old_b));
    tick();
    chk("rbw_rdy1",  32'(M_DataRdy),   32'd2);
    chk("rbw_data1", 32'(M_Rdata_ram), 32'd0);
    tick();
    side_rd(9, "rbw_rb");

    // Out-of-range read held for 10 cycles
    set_req(0, 1'b1, 1'b0, 40, 8'h00, 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("oor_rdy_%0d", i),  32'(M_DataRdy),   32'd0);
      chk($sformatf("oor_data_%0d", i), 32'(M_Rdata_ram), 32'd0);
    end
    clear_req();
    chk("oor_err", 32'(err), 32'd0);

    // oe and we together on one channel
    set_req(0, 1'b1, 1'b1, 3, 8'h00, 8);
    tick();
    clear_req();
    chk("conf_err", 32'(err), 32'd1);
    run_txn(0, 1'b0, 3, 8'h00, 8, "post_conf");
    chk("conf_err_sticky", 32'(err), 32'd1);

    // Reset one cycle into RD_WAIT
    set_req(0, 1'b1, 1'b0, 3, 8'h00, 8);
    tick();
    clear_req();
    tick();
    #1 reset = 1'b0;
    #1;
    chk("mrst_rdy",   32'(M_DataRdy),   32'd0);
    chk("mrst_rdata", 32'(M_Rdata_ram), 32'd0);
    chk("mrst_err",   32'(err),         32'd0);
    chk("mrst_ldrd",  32'(ld_rdata),    32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst_hold_rdy_%0d", i), 32'(M_DataRdy), 32'd0);
    end
    reset = 1'b1;
    tick();
    run_txn(0, 1'b0, 3, 8'h00, 8, "post_rst");
    side_rd(3, "post_rst_rb");

    // Side-port access while a channel is busy is rejected
    set_req(0, 1'b1, 1'b0, 3, 8'h00, 8);
    tick();
    clear_req();
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = 5'd3; ld_wdata = ~model[3];
    tick();
    ld_en = 1'b0; ld_we = 1'b0;
    chk("busy_ld_err", 32'(err), 32'd1);
    tick();
    chk("busy_ld_rdy",  32'(M_DataRdy),   32'd1);
    chk("busy_ld_data", 32'(M_Rdata_ram), 32'(model[3]));
    tick();
    side_rd(3, "busy_ld_rb");

    // Randomised single-channel traffic against the model
    for (int n = 0; n < 40; n++) begin
      c  = int'($urandom_range(0, N_CH - 1));
      wr = 1'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(MEM_SIZE, 127));
      else                           a = int'($urandom_range(0, MEM_SIZE - 1));
      run_txn(c, wr, a, 8'($urandom), sz, $sformatf("rnd%0d", n));
    end
    for (int i = 0; i < MEM_SIZE; i++) side_rd(i, $sformatf("final_rb_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
